// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state type and iteration constants.
package mips_pkg;

  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned MD_CNT_W = 6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/mips_muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// One shared 33-bit adder/subtractor serves both shift-add and restoring divide.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e           state, state_nx;
  logic [MD_CNT_W-1:0] cnt;
  logic                accept_c, iter_c, fix_c, wr_c;

  // acc: partial-product high half (mult) or partial remainder (div)
  logic [WIDTH:0]      acc;
  logic [WIDTH-1:0]    mq, opb, rs_q;
  logic                is_div_q, neg_q, neg_rem_q, dbz_q;

  md_op_e              op_c;
  logic                sgn_c, is_div_c;
  logic [WIDTH-1:0]    a_mag, b_mag;

  logic [WIDTH:0]      add_a, add_b, mul_s;
  logic                add_cin;
  logic [WIDTH+1:0]    add_s;
  logic                div_ok;

  logic [2*WIDTH-1:0]  prod_mag, prod_fix;
  logic [WIDTH-1:0]    q_fix, r_fix;

  // Next-state and control decode
  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    iter_c   = 1'b0;
    fix_c    = 1'b0;
    wr_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_nx = ST_RUN;
        end else begin
          wr_c = 1'b1;
        end
      end
      ST_RUN: begin
        iter_c = 1'b1;
        if (cnt == MD_CNT_W'(MD_ITERS - 1)) state_nx = ST_FIX;
      end
      ST_FIX: begin
        fix_c    = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand magnitudes; the unsigned ops take raw values
  always_comb begin
    op_c     = md_op_e'(op);
    sgn_c    = (op_c == MD_MULT) || (op_c == MD_DIV);
    is_div_c = (op_c == MD_DIV) || (op_c == MD_DIVU);
    a_mag    = (sgn_c && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    b_mag    = (sgn_c && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  end

  // Shared adder: add for multiply, a + ~b + 1 for divide (carry-out = no borrow)
  always_comb begin
    if (is_div_q) begin
      add_a   = {acc[WIDTH-1:0], mq[WIDTH-1]};
      add_b   = ~{1'b0, opb};
      add_cin = 1'b1;
    end else begin
      add_a   = acc;
      add_b   = {1'b0, opb};
      add_cin = 1'b0;
    end
    add_s  = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(add_cin);
    div_ok = add_s[WIDTH+1];
    mul_s  = mq[0] ? add_s[WIDTH:0] : acc;
  end

  // Sign correction applied in the FIX cycle
  always_comb begin
    prod_mag = {acc[WIDTH-1:0], mq};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    q_fix    = neg_q ? -mq : mq;
    r_fix    = neg_rem_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  // Control state and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state       <= state_nx;
      done        <= fix_c;
      div_by_zero <= fix_c & dbz_q;
      if (accept_c) begin
        busy <= 1'b1;
        cnt  <= '0;
      end else if (iter_c) begin
        cnt <= cnt + MD_CNT_W'(1);
      end else if (fix_c) begin
        busy <= 1'b0;
      end
      if (fix_c) begin
        if (dbz_q) begin
          hi <= rs_q;
          lo <= '1;
        end else if (is_div_q) begin
          hi <= r_fix;
          lo <= q_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end else if (wr_c) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

  // Iteration datapath; contents are don't-care outside an operation
  always_ff @(posedge clk) begin
    if (accept_c) begin
      acc       <= '0;
      mq        <= a_mag;
      opb       <= b_mag;
      rs_q      <= rs_val;
      is_div_q  <= is_div_c;
      neg_q     <= sgn_c & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      neg_rem_q <= sgn_c & rs_val[WIDTH-1];
      dbz_q     <= is_div_c & (rt_val == '0);
    end else if (iter_c) begin
      if (is_div_q) begin
        acc <= {1'b0, div_ok ? add_s[WIDTH-1:0] : add_a[WIDTH-1:0]};
        mq  <= {mq[WIDTH-2:0], div_ok};
      end else begin
        acc <= {1'b0, mul_s[WIDTH:1]};
        mq  <= {mul_s[0], mq[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed table-driven bench for mips_muldiv plus hand-written sequences
// for busy-time requests, same-cycle write/start and mid-operation reset.
module tb_mips_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata;
  logic        hi_we, lo_we;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the done pulse; lat=0 means it never came
  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edbz);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_done_lo"}, 32'(done), 32'd0);
    wait_done(lat);
    check({name, "_lat"}, 32'(lat), 32'd33);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
    check({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone, lat;
    logic [31:0] cap_hi, cap_lo;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{2'b00, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0};
    vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[13] = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;

    // Idle MTHI / MTLO
    @(negedge clk); hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A5A5A;
    @(negedge clk); lo_we = 1'b0;
    check("mthi", hi, 32'hA5A5A5A5);
    check("mtlo", lo, 32'h5A5A5A5A);

    // Start and write while busy are ignored; HI/LO hold until done
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat = 0; cap_hi = '0; cap_lo = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 5) begin
        start = 1'b1; op = 2'b10; rs_val = 32'd100; rt_val = 32'd0;
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(posedge clk); #1;
      if (c == 10) begin
        check("hold_hi", hi, 32'hA5A5A5A5);
        check("hold_lo", lo, 32'h5A5A5A5A);
      end
      if (done) begin
        ndone++;
        lat = c;
        cap_hi = hi;
        cap_lo = lo;
      end
    end
    check("busy_ndone", 32'(ndone), 32'd1);
    check("busy_lat", 32'(lat), 32'd33);
    check("busy_hi", cap_hi, 32'd0);
    check("busy_lo", cap_lo, 32'd15);
    check("busy_hi_final", hi, 32'd0);

    // Start and MTHI in the same idle cycle: the write is dropped
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'd2; rt_val = 32'd3;
    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("same_hi_now", hi, 32'd0);
    wait_done(lat);
    check("same_lat", 32'(lat), 32'd33);
    check("same_hi", hi, 32'd0);
    check("same_lo", lo, 32'd6);

    // Table vectors, issued back to back
    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].ehi, vecs[i].elo, vecs[i].edbz);

    // Reset during iteration 10 aborts without a done pulse
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    if (done) ndone++;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(ndone), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    rst_n = 1'b1;
    run_op("post_rst", 2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
